// File: rtl/branch_history_table_if.sv
// Predictor bus between the pipeline and branch_history_table.
//   master : pipeline side; drives the IF-stage query and the EX-stage resolution
//   slave  : predictor side; returns the prediction, history snapshot and statistics
// Signals:
//   pred_pc/pred_taken/pred_ghr : fetch-time query and answer
//   upd_valid/upd_pc/upd_ghr/upd_taken/upd_predicted : one resolved branch per cycle
//   mispredict/branch_count/mispredict_count : statistics
interface branch_history_table_if #(
   parameter int unsigned HIST_LEN  = 4,
   parameter int unsigned CNT_WIDTH = 32
);
   // A zero-length history still needs a one-bit carrier through the pipe.
   localparam int unsigned GhrW = (HIST_LEN > 0) ? HIST_LEN : 1;

   logic [31:0]          pred_pc;
   logic                 pred_taken;
   logic [GhrW-1:0]      pred_ghr;
   logic                 upd_valid;
   logic [31:0]          upd_pc;
   logic [GhrW-1:0]      upd_ghr;
   logic                 upd_taken;
   logic                 upd_predicted;
   logic                 mispredict;
   logic [CNT_WIDTH-1:0] branch_count;
   logic [CNT_WIDTH-1:0] mispredict_count;

   modport master (
      output pred_pc, upd_valid, upd_pc, upd_ghr, upd_taken, upd_predicted,
      input  pred_taken, pred_ghr, mispredict, branch_count, mispredict_count
   );

   modport slave (
      input  pred_pc, upd_valid, upd_pc, upd_ghr, upd_taken, upd_predicted,
      output pred_taken, pred_ghr, mispredict, branch_count, mispredict_count
   );
endinterface

// File: rtl/branch_history_table.sv
// Gshare branch predictor: a table of 2-bit saturating counters (00 strong-NT .. 11 strong-T)
// indexed by PC[IDX_BITS+1:2] XOR global history. Prediction is combinational; training,
// history repair and statistics update on the clock edge after a resolved branch.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : synchronous active-high reset; drops any concurrent update
//   bus  : branch_history_table_if slave (query, resolution, statistics)
module branch_history_table #(
   parameter int unsigned IDX_BITS  = 8,
   parameter int unsigned HIST_LEN  = 4,
   parameter int unsigned CNT_WIDTH = 32
) (
   input logic                    clk,
   input logic                    rst,
   branch_history_table_if.slave  bus
);
   localparam int unsigned Entries = 2 ** IDX_BITS;

   typedef logic [1:0] ctr_t;

   ctr_t                 table_q [Entries];
   logic [IDX_BITS-1:0]  hist_pred, hist_upd;
   logic [IDX_BITS-1:0]  pred_idx, upd_idx;
   ctr_t                 upd_cur, upd_nxt;
   logic                 upd_miss;
   logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;
   logic                 mispredict_q, mispredict_d;

   // Only the index bits of the PCs are used.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{bus.pred_pc[31:IDX_BITS+2], bus.pred_pc[1:0],
                             bus.upd_pc[31:IDX_BITS+2], bus.upd_pc[1:0]};

   if (HIST_LEN > 0) begin : g_hist
      logic [HIST_LEN-1:0] ghr_q;
      logic [HIST_LEN:0]   shifted;

      // Rebuilt from the carried snapshot, so a flush repairs the history for free.
      assign shifted = {bus.upd_ghr, bus.upd_taken};

      always_ff @(posedge clk) begin
         if (rst) begin
            ghr_q <= '0;
         end else if (bus.upd_valid) begin
            ghr_q <= shifted[HIST_LEN-1:0];
         end
      end

      assign hist_pred    = IDX_BITS'(ghr_q);
      assign hist_upd     = IDX_BITS'(bus.upd_ghr);
      assign bus.pred_ghr = ghr_q;
   end else begin : g_bimodal
      logic unused_upd_ghr;
      assign unused_upd_ghr = ^bus.upd_ghr;
      assign hist_pred      = '0;
      assign hist_upd       = '0;
      assign bus.pred_ghr   = '0;
   end

   assign pred_idx       = bus.pred_pc[IDX_BITS+1:2] ^ hist_pred;
   assign upd_idx        = bus.upd_pc[IDX_BITS+1:2] ^ hist_upd;
   // Reads the registered table, so a same-cycle update to this entry is not bypassed.
   assign bus.pred_taken = table_q[pred_idx][1];

   always_comb begin
      upd_cur = table_q[upd_idx];
      upd_nxt = upd_cur;
      if (bus.upd_taken && upd_cur != 2'b11) begin
         upd_nxt = upd_cur + 2'b01;
      end else if (!bus.upd_taken && upd_cur != 2'b00) begin
         upd_nxt = upd_cur - 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < Entries; i++) begin
            table_q[i] <= 2'b01;
         end
      end else if (bus.upd_valid) begin
         table_q[upd_idx] <= upd_nxt;
      end
   end

   assign upd_miss = bus.upd_taken ^ bus.upd_predicted;

   always_comb begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      mispredict_d  = 1'b0;
      if (bus.upd_valid) begin
         mispredict_d = upd_miss;
         // Saturate rather than wrap.
         if (!(&branch_cnt_q)) begin
            branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
         end
         if (upd_miss && !(&mispred_cnt_q)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
         mispredict_q  <= 1'b0;
      end else begin
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
         mispredict_q  <= mispredict_d;
      end
   end

   assign bus.branch_count     = branch_cnt_q;
   assign bus.mispredict_count = mispred_cnt_q;
   assign bus.mispredict       = mispredict_q;
endmodule
